// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy stalls MDU instructions in D.
// Optional `MDU_CANCEL_EN adds a cancel input that discards an in-flight operation.
module e_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_next;
  logic [CW-1:0]      r_cnt, w_cnt_next;
  logic [3:0]         r_op, w_op_next;
  logic [WIDTH-1:0]   r_a, w_a_next;
  logic [WIDTH-1:0]   r_b, w_b_next;
  logic [WIDTH-1:0]   r_hi, w_hi_next;
  logic [WIDTH-1:0]   r_lo, w_lo_next;
  logic               r_busy, w_busy_next;
  logic               w_cancel;

  logic [2*WIDTH-1:0] w_prod_s, w_prod_u, w_acc;
  logic [WIDTH-1:0]   w_quo_s, w_rem_s, w_quo_u, w_rem_u, w_min;
  logic               w_div_ovf, w_div_zero;

`ifdef MDU_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif

  // Results are formed from the latched operands and the live HI/LO at commit time.
  assign w_prod_s   = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
  assign w_prod_u   = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_acc      = {r_hi, r_lo};
  assign w_min      = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_div_zero = (r_b == '0);
  assign w_div_ovf  = (r_a == w_min) && (r_b == '1);
  assign w_quo_s    = $signed(r_a) / $signed(r_b);
  assign w_rem_s    = $signed(r_a) % $signed(r_b);
  assign w_quo_u    = r_a / r_b;
  assign w_rem_u    = r_a % r_b;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_busy_next  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (start && !w_cancel) begin
          case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
            OP_DIV, OP_DIVU: begin
              w_op_next    = op;
              w_a_next     = src_a;
              w_b_next     = src_b;
              w_cnt_next   = (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              w_state_next = S_RUN;
              w_busy_next  = 1'b1;
            end
            OP_MTHI: w_hi_next = src_a;
            OP_MTLO: w_lo_next = src_a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (w_cancel) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_busy_next  = 1'b0;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            w_state_next = S_IDLE;
            w_busy_next  = 1'b0;
            case (r_op)
              OP_MULT:  {w_hi_next, w_lo_next} = w_prod_s;
              OP_MULTU: {w_hi_next, w_lo_next} = w_prod_u;
              OP_MADD:  {w_hi_next, w_lo_next} = w_acc + w_prod_s;
              OP_MADDU: {w_hi_next, w_lo_next} = w_acc + w_prod_u;
              OP_MSUB:  {w_hi_next, w_lo_next} = w_acc - w_prod_s;
              OP_MSUBU: {w_hi_next, w_lo_next} = w_acc - w_prod_u;
              OP_DIV: begin
                // MIN / -1 overflows the quotient; pin it explicitly.
                if (w_div_ovf) begin
                  w_lo_next = w_min;
                  w_hi_next = '0;
                end else if (!w_div_zero) begin
                  w_lo_next = w_quo_s;
                  w_hi_next = w_rem_s;
                end
              end
              OP_DIVU: begin
                if (!w_div_zero) begin
                  w_lo_next = w_quo_u;
                  w_hi_next = w_rem_u;
                end
              end
              default: ;
            endcase
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_op    <= w_op_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      r_busy  <= w_busy_next;
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases then random ops against an arithmetic model.
// Define MDU_CANCEL_EN for both files to exercise the cancel path.
module tb_e_mdu;
  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy;
  logic [31:0] hi, lo;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef MDU_CANCEL_EN
    .cancel(cancel),
`endif
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int cycles_of(input logic [3:0] o);
    if (o == 4'd3 || o == 4'd4) return 10;
    if (o == 4'd1 || o == 4'd2 || (o >= 4'd7 && o <= 4'd10)) return 5;
    return 0;
  endfunction

  // Reference model: plain 64-bit / int arithmetic straight from the op definitions.
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      ps;
    logic [63:0] pu, acc;
    int          sa, sb;
    ps  = longint'($signed(a)) * longint'($signed(b));
    pu  = {32'd0, a} * {32'd0, b};
    acc = {m_hi, m_lo};
    sa  = a;
    sb  = b;
    case (o)
      4'd1:  {m_hi, m_lo} = ps;
      4'd2:  {m_hi, m_lo} = pu;
      4'd7:  {m_hi, m_lo} = acc + ps;
      4'd8:  {m_hi, m_lo} = acc + pu;
      4'd9:  {m_hi, m_lo} = acc - ps;
      4'd10: {m_hi, m_lo} = acc - pu;
      4'd3: begin
        if (b == 32'hFFFFFFFF && a == 32'h80000000) begin
          m_lo = 32'h80000000; m_hi = 32'd0;
        end else if (b != 0) begin
          m_lo = sa / sb; m_hi = sa % sb;
        end
      end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd5:  m_hi = a;
      4'd6:  m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int n, cnt;
    logic [31:0] old_hi, old_lo;
    @(negedge clk);
    check("protocol_idle", {31'd0, busy}, 32'd0);
    old_hi = m_hi; old_lo = m_lo;
    op = o; src_a = a; src_b = b; start = 1'b1;
    n = cycles_of(o);
    model(o, a, b);
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    if (n == 0) begin
      check("nobusy", {31'd0, busy}, 32'd0);
    end else begin
      check("hold_hi", hi, old_hi);
      check("hold_lo", lo, old_lo);
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
        cnt++;
        @(posedge clk); #1;
      end
      check("busy_cycles", cnt, n);
    end
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h", o, a, b, hi, lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    m_hi = '0; m_lo = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b1;

    run_op(4'd1, 32'hFFFFFFFF, 32'd2);
    check("t1_hi", hi, 32'hFFFFFFFF); check("t1_lo", lo, 32'hFFFFFFFE);
    run_op(4'd2, 32'hFFFFFFFF, 32'd2);
    check("t2_hi", hi, 32'h00000001); check("t2_lo", lo, 32'hFFFFFFFE);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2);
    check("t3_hi", hi, 32'hFFFFFFFF); check("t3_lo", lo, 32'hFFFFFFFD);
    run_op(4'd4, 32'd7, 32'd0);
    check("t3z_hi", hi, 32'hFFFFFFFF); check("t3z_lo", lo, 32'hFFFFFFFD);
    run_op(4'd6, 32'hFFFFFFFF, 32'd0);
    run_op(4'd5, 32'd0, 32'd0);
    run_op(4'd7, 32'd1, 32'd1);
    check("t4_hi", hi, 32'h1); check("t4_lo", lo, 32'h0);
    run_op(4'd9, 32'd1, 32'd1);
    check("t4s_hi", hi, 32'h0); check("t4s_lo", lo, 32'hFFFFFFFF);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
    check("ovf_hi", hi, 32'h0); check("ovf_lo", lo, 32'h80000000);
    run_op(4'd12, 32'h1234, 32'h5678);

    // Async reset in the middle of busy cycle 4 of a DIV.
    @(negedge clk);
    op = 4'd3; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; op = 4'd0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk); reset = 1'b1;

`ifdef MDU_CANCEL_EN
    run_op(4'd5, 32'h5, 32'd0);
    run_op(4'd6, 32'h5, 32'd0);
    @(negedge clk);
    op = 4'd1; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; op = 4'd0;
    @(negedge clk); cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_hi", hi, 32'h5);
    check("cancel_lo", lo, 32'h5);
    run_op(4'd1, 32'd3, 32'd4);
`endif

    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
